// File: rtl/data_mem_arbiter_if.sv
// Request/response bundle for one data_memory requester (CPU or debug loader).
// The requester uses the master modport, the arbiter the slave modport.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the 16x8 data_memory: serialises CPU and debug
// accesses into one 2-cycle IDLE/ACCESS slot and routes read data back to the owner.
module data_mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int FAIR   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  data_mem_arbiter_if.slave cpu,
  data_mem_arbiter_if.slave dbg,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy
);
  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state;
  logic   last_dbg;
  logic   owner_dbg;

  logic              any_req;
  logic              win_dbg;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Debug wins alone, or on a tie when round-robin is on and the CPU went last.
  assign any_req   = cpu.req | dbg.req;
  assign win_dbg   = dbg.req & (~cpu.req | ((FAIR != 0) & ~last_dbg));
  assign sel_we    = win_dbg ? dbg.we    : cpu.we;
  assign sel_addr  = win_dbg ? dbg.addr  : cpu.addr;
  assign sel_wdata = win_dbg ? dbg.wdata : cpu.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_dbg   <= 1'b1;
      owner_dbg  <= 1'b0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      cpu.gnt    <= 1'b0;
      cpu.rvalid <= 1'b0;
      cpu.rdata  <= '0;
      dbg.gnt    <= 1'b0;
      dbg.rvalid <= 1'b0;
      dbg.rdata  <= '0;
    end else begin
      cpu.rvalid <= 1'b0;
      dbg.rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            owner_dbg <= win_dbg;
            last_dbg  <= win_dbg;
            cpu.gnt   <= ~win_dbg;
            dbg.gnt   <= win_dbg;
            mem_addr  <= sel_addr;
            mem_read  <= ~sel_we;
            mem_write <= sel_we;
            mem_wdata <= sel_we ? sel_wdata : '0;
          end
        end
        ACCESS: begin
          // Requests are ignored here; the slot always closes after one cycle.
          state     <= IDLE;
          busy      <= 1'b0;
          cpu.gnt   <= 1'b0;
          dbg.gnt   <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (mem_read) begin
            if (owner_dbg) begin
              dbg.rdata  <= mem_data;
              dbg.rvalid <= 1'b1;
            end else begin
              cpu.rdata  <= mem_data;
              cpu.rvalid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a round-robin instance on a RAM model
// plus a fixed-priority instance fed the same requests.
module tb_data_mem_arbiter;
  logic clk;
  logic rst_n;

  data_mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) cpu_a ();
  data_mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) dbg_a ();
  data_mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) cpu_b ();
  data_mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) dbg_b ();

  logic [3:0] mem_addr_a, mem_addr_b;
  logic [7:0] mem_wdata_a, mem_wdata_b, mem_data_a, mem_data_b;
  logic       mem_read_a, mem_read_b, mem_write_a, mem_write_b, busy_a, busy_b;

  logic [7:0] ram [16];

  int n_vec = 0;
  int n_err = 0;

  data_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .FAIR(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .cpu(cpu_a), .dbg(dbg_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_read(mem_read_a),
    .mem_write(mem_write_a), .mem_data(mem_data_a), .busy(busy_a)
  );

  data_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .FAIR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .cpu(cpu_b), .dbg(dbg_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_read(mem_read_b),
    .mem_write(mem_write_b), .mem_data(mem_data_b), .busy(busy_b)
  );

  assign cpu_b.req   = cpu_a.req;
  assign cpu_b.we    = cpu_a.we;
  assign cpu_b.addr  = cpu_a.addr;
  assign cpu_b.wdata = cpu_a.wdata;
  assign dbg_b.req   = dbg_a.req;
  assign dbg_b.we    = dbg_a.we;
  assign dbg_b.addr  = dbg_a.addr;
  assign dbg_b.wdata = dbg_a.wdata;
  assign mem_data_b  = '0;

  // data_memory model: combinational read, write on the clock edge.
  assign mem_data_a = ram[mem_addr_a];
  always @(posedge clk) begin
    if (mem_write_a) ram[mem_addr_a] <= mem_wdata_a;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [63:0] all_outs_a();
    return {cpu_a.gnt, cpu_a.rvalid, cpu_a.rdata, dbg_a.gnt, dbg_a.rvalid, dbg_a.rdata,
            mem_addr_a, mem_wdata_a, mem_read_a, mem_write_a, busy_a};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    rst_n       = 1'b0;
    cpu_a.req   = 1'b1; cpu_a.we = 1'b0; cpu_a.addr = 4'd0; cpu_a.wdata = 8'h00;
    dbg_a.req   = 1'b1; dbg_a.we = 1'b0; dbg_a.addr = 4'd7; dbg_a.wdata = 8'h00;

    // Reset with both requests high: everything quiet.
    @(negedge clk);
    check_val("reset_outs_rr", all_outs_a(), 64'h0);
    check_val("reset_busy_fp", {63'h0, busy_b}, 64'h0);
    @(negedge clk);
    check_val("reset_outs_rr_2", all_outs_a(), 64'h0);

    // Contention: release reset as cycle 0, both requests held.
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_val($sformatf("contend_gnt_c%0d", k),
                {60'h0, cpu_a.gnt, dbg_a.gnt, cpu_b.gnt, dbg_b.gnt},
                {60'h0, (k == 1 || k == 5), (k == 3 || k == 7), (k % 2 == 1), 1'b0});
      if (k == 8) begin
        cpu_a.req = 1'b0;
        dbg_a.req = 1'b0;
      end
    end
    check_val("contend_dbg_rdata", {56'h0, dbg_a.rdata}, 64'h07);
    check_val("contend_dbg_rvalid", {63'h0, dbg_a.rvalid}, 64'h1);

    // CPU read of address 3.
    @(negedge clk);
    cpu_a.req = 1'b1; cpu_a.we = 1'b0; cpu_a.addr = 4'd3;
    @(negedge clk);
    check_val("rd3_c1", {56'h0, cpu_a.gnt, dbg_a.gnt, mem_read_a, mem_write_a, mem_addr_a},
              {56'h0, 4'b1010, 4'd3});
    cpu_a.req = 1'b0;
    @(negedge clk);
    check_val("rd3_c2", {52'h0, cpu_a.rvalid, mem_read_a, busy_a, 1'b0, cpu_a.rdata},
              {52'h0, 4'b1000, 8'h03});

    // Debug write A5 to 15, then CPU reads it back.
    dbg_a.req = 1'b1; dbg_a.we = 1'b1; dbg_a.addr = 4'd15; dbg_a.wdata = 8'hA5;
    @(negedge clk);
    check_val("wr15_c1", {48'h0, dbg_a.gnt, cpu_a.gnt, mem_read_a, mem_write_a, mem_addr_a, mem_wdata_a},
              {48'h0, 4'b1001, 4'd15, 8'hA5});
    dbg_a.req = 1'b0;
    @(negedge clk);
    check_val("wr15_c2", {60'h0, dbg_a.rvalid, mem_write_a, busy_a, 1'b0}, 64'h0);
    check_val("wr15_dbg_rdata_kept", {56'h0, dbg_a.rdata}, 64'h07);
    check_val("wr15_ram", {56'h0, ram[15]}, 64'hA5);
    cpu_a.req = 1'b1; cpu_a.we = 1'b0; cpu_a.addr = 4'd15;
    @(negedge clk);
    check_val("rd15_c1", {60'h0, cpu_a.gnt, mem_read_a, mem_write_a, dbg_a.rvalid}, 64'b1100);
    cpu_a.req = 1'b0;
    @(negedge clk);
    check_val("rd15_c2", {52'h0, cpu_a.rvalid, dbg_a.rvalid, 2'b00, cpu_a.rdata}, {52'h0, 4'b1000, 8'hA5});

    // Back-to-back CPU reads of 1 then 2 with req held.
    cpu_a.req = 1'b1; cpu_a.we = 1'b0; cpu_a.addr = 4'd1;
    @(negedge clk);
    check_val("b2b_c1", {56'h0, cpu_a.gnt, 3'b000, mem_addr_a}, {56'h0, 4'b1000, 4'd1});
    cpu_a.addr = 4'd2;
    @(negedge clk);
    check_val("b2b_c2", {52'h0, cpu_a.rvalid, cpu_a.gnt, 2'b00, cpu_a.rdata}, {52'h0, 4'b1000, 8'h01});
    @(negedge clk);
    check_val("b2b_c3", {56'h0, cpu_a.gnt, 3'b000, mem_addr_a}, {56'h0, 4'b1000, 4'd2});
    cpu_a.req = 1'b0;
    @(negedge clk);
    check_val("b2b_c4", {52'h0, cpu_a.rvalid, 3'b000, cpu_a.rdata}, {52'h0, 4'b1000, 8'h02});

    // Debug write 5A to 4 aborted by reset in the middle of its ACCESS cycle.
    dbg_a.req = 1'b1; dbg_a.we = 1'b1; dbg_a.addr = 4'd4; dbg_a.wdata = 8'h5A;
    @(negedge clk);
    check_val("abort_c1", {62'h0, dbg_a.gnt, mem_write_a}, 64'b11);
    dbg_a.req = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_val("abort_async", all_outs_a(), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val($sformatf("abort_quiet_%0d", k), {62'h0, dbg_a.gnt, dbg_a.rvalid}, 64'h0);
    end
    check_val("abort_ram4", {56'h0, ram[4]}, 64'h04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
